// File: rtl/load_controller_if.sv
// ---------------------------------------------------------------------------
// load_controller_if
//   Bundles the request and memory/switch/core signals of the load
//   controller.
//
//   Parameters
//     NUM_ROWS  rows per load sequence; sets the width of rowaddrtoSw
//     ADDR_W    row address width
//
//   Signals (direction shown for the master side, the controller itself)
//     load_req     in   start a load sequence
//     memRD        out  data memory read strobe
//     swEnable     out  switch enable, memory bus to core registers
//     memRdtoReg   out  core register write enable
//     rowaddr      out  memory row address
//     rowaddrtoSw  out  one-hot row select to the switch
//     coreStart    out  one-cycle start pulse, bit i to core i+1
//     busy         out  sequence in progress
//
//   Modports
//     master  the controller
//     slave   the environment that issues requests and observes outputs
// ---------------------------------------------------------------------------
interface load_controller_if #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = 4
);
  logic                load_req;
  logic                memRD;
  logic                swEnable;
  logic                memRdtoReg;
  logic [ADDR_W-1:0]   rowaddr;
  logic [NUM_ROWS-1:0] rowaddrtoSw;
  logic [3:0]          coreStart;
  logic                busy;

  modport master (
    input  load_req,
    output memRD,
    output swEnable,
    output memRdtoReg,
    output rowaddr,
    output rowaddrtoSw,
    output coreStart,
    output busy
  );

  modport slave (
    output load_req,
    input  memRD,
    input  swEnable,
    input  memRdtoReg,
    input  rowaddr,
    input  rowaddrtoSw,
    input  coreStart,
    input  busy
  );
endinterface

// File: rtl/load_controller.sv
// ---------------------------------------------------------------------------
// load_controller
//   Reads NUM_ROWS operand rows from data memory into the core registers,
//   one row per transaction, routing each row through the switch.  After the
//   last row is captured it pulses coreStart to all four cores.
//
//   Each row takes one READ cycle, MEM_LAT-1 WAIT cycles and one CAPTURE
//   cycle.  A START cycle follows the last row, then the controller returns
//   to IDLE.  Requests arriving while busy are dropped.
//
//   Parameters
//     NUM_ROWS  rows per request (2..16)
//     ADDR_W    row address width, 2**ADDR_W >= NUM_ROWS
//     MEM_LAT   data memory read latency in cycles (1..4)
//
//   Ports
//     clk   system clock, rising edge
//     rstn  asynchronous active-low reset
//     bus   load_controller_if master modport (request, memory, switch,
//           core start and busy signals)
//
//   Every output is a flop loaded from the next-state values, so the outputs
//   describe the state being entered and nothing reaches them combinationally
//   from load_req.
// ---------------------------------------------------------------------------
module load_controller #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = 4,
  parameter int MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  load_controller_if.master bus
);

  // The wait counter only has to count up to MEM_LAT-2.
  localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    START   = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   row_reg, row_next;
  logic [LAT_W-1:0]    lat_reg, lat_next;

  // Output flops and the values they load.
  logic                mem_rd_reg, mem_rd_next;
  logic                capture_reg, capture_next;
  logic [ADDR_W-1:0]   rowaddr_reg, rowaddr_next;
  logic [NUM_ROWS-1:0] row_sel_reg, row_sel_next;
  logic [3:0]          core_start_reg, core_start_next;
  logic                busy_reg, busy_next;

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      lat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      lat_reg   <= lat_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    lat_next   = lat_reg;

    case (state_reg)
      IDLE: begin
        lat_next = '0;
        if (bus.load_req) begin
          state_next = READ;
          row_next   = '0;
        end
      end

      READ: begin
        lat_next = '0;
        // With single-cycle memory the data is ready for the next edge.
        if (MEM_LAT > 1) begin
          state_next = WAIT;
        end else begin
          state_next = CAPTURE;
        end
      end

      WAIT: begin
        if (lat_reg == LAT_LAST) begin
          state_next = CAPTURE;
          lat_next   = '0;
        end else begin
          lat_next = lat_reg + LAT_W'(1);
        end
      end

      CAPTURE: begin
        lat_next = '0;
        // The row counter stops at the last row, so it never wraps.
        if (row_reg == ROW_LAST) begin
          state_next = START;
        end else begin
          state_next = READ;
          row_next   = row_reg + ADDR_W'(1);
        end
      end

      START: begin
        state_next = IDLE;
        row_next   = '0;
        lat_next   = '0;
      end

      default: begin
        state_next = IDLE;
        row_next   = '0;
        lat_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output values for the state being entered
  // -------------------------------------------------------------------------
  always_comb begin
    mem_rd_next     = 1'b0;
    capture_next    = 1'b0;
    rowaddr_next    = '0;
    core_start_next = 4'b0000;
    busy_next       = 1'b0;

    case (state_next)
      READ, WAIT: begin
        mem_rd_next  = 1'b1;
        rowaddr_next = row_next;
        busy_next    = 1'b1;
      end

      CAPTURE: begin
        mem_rd_next  = 1'b1;
        capture_next = 1'b1;
        rowaddr_next = row_next;
        busy_next    = 1'b1;
      end

      START: begin
        core_start_next = 4'b1111;
        busy_next       = 1'b1;
      end

      default: begin
        mem_rd_next = 1'b0;
      end
    endcase
  end

  // One-hot switch select, live only while a row is being captured.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row_sel
    assign row_sel_next[gi] = (state_next == CAPTURE) && (row_next == ADDR_W'(gi));
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_rd_reg     <= 1'b0;
      capture_reg    <= 1'b0;
      rowaddr_reg    <= '0;
      row_sel_reg    <= '0;
      core_start_reg <= 4'b0000;
      busy_reg       <= 1'b0;
    end else begin
      mem_rd_reg     <= mem_rd_next;
      capture_reg    <= capture_next;
      rowaddr_reg    <= rowaddr_next;
      row_sel_reg    <= row_sel_next;
      core_start_reg <= core_start_next;
      busy_reg       <= busy_next;
    end
  end

  // swEnable and memRdtoReg come from one flop, so they always match.
  assign bus.memRD       = mem_rd_reg;
  assign bus.swEnable    = capture_reg;
  assign bus.memRdtoReg  = capture_reg;
  assign bus.rowaddr     = rowaddr_reg;
  assign bus.rowaddrtoSw = row_sel_reg;
  assign bus.coreStart   = core_start_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_load_controller.sv
// ---------------------------------------------------------------------------
// tb_load_controller
//   Runs three load_controller instances side by side:
//     inst 0: NUM_ROWS=16, MEM_LAT=1  (default configuration)
//     inst 1: NUM_ROWS=4,  MEM_LAT=3  (long memory latency)
//     inst 2: NUM_ROWS=16, MEM_LAT=2  (has WAIT cycles, used for the abort)
//   The reference model tracks only the cycle index since the acceptance
//   edge.  It derives the expected row, phase and start pulse from that index
//   using division and remainder.
// ---------------------------------------------------------------------------
module tb_load_controller;

  localparam int NI     = 3;
  localparam int ADDR_W = 4;

  function automatic int cfg_rows(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic [NI-1:0] rstn_v;
  logic [NI-1:0] req_v;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int N   = cfg_rows(gi);
    localparam int L   = cfg_lat(gi);
    localparam int TOT = N * (1 + L);

    load_controller_if #(.NUM_ROWS(N), .ADDR_W(ADDR_W)) bus ();
    assign bus.load_req = req_v[gi];

    load_controller #(
      .NUM_ROWS(N),
      .ADDR_W  (ADDR_W),
      .MEM_LAT (L)
    ) dut (
      .clk (clk),
      .rstn(rstn_v[gi]),
      .bus (bus)
    );

    // Reference model: active covers the cycles from the acceptance edge
    // through the start cycle.  k is the cycle index within that span.
    bit active = 1'b0;
    int k      = 0;
    int starts_exp = 0;
    int starts_got = 0;

    always @(posedge clk or negedge rstn_v[gi]) begin
      if (!rstn_v[gi]) begin
        active <= 1'b0;
        k      <= 0;
      end else if (active) begin
        if (k == TOT) begin
          active <= 1'b0;
          k      <= 0;
        end else begin
          k <= k + 1;
        end
      end else if (req_v[gi]) begin
        active <= 1'b1;
        k      <= 0;
      end
    end

    logic              e_rd, e_cap, e_busy;
    logic [3:0]        e_cs;
    logic [ADDR_W-1:0] e_addr;
    logic [N-1:0]      e_sel;
    int                row, ph;

    always @(negedge clk) begin
      e_rd   = 1'b0;
      e_cap  = 1'b0;
      e_busy = 1'b0;
      e_cs   = 4'h0;
      e_addr = '0;
      e_sel  = '0;
      row    = 0;
      ph     = 0;
      if (active) begin
        e_busy = 1'b1;
        if (k == TOT) begin
          e_cs = 4'hF;
        end else begin
          row    = k / (1 + L);
          ph     = k % (1 + L);
          e_rd   = 1'b1;
          e_addr = ADDR_W'(row);
          e_cap  = (ph == L);
          if (e_cap) e_sel[row] = 1'b1;
        end
      end

      check($sformatf("i%0d.memRD", gi),       32'(bus.memRD),       32'(e_rd));
      check($sformatf("i%0d.swEnable", gi),    32'(bus.swEnable),    32'(e_cap));
      check($sformatf("i%0d.memRdtoReg", gi),  32'(bus.memRdtoReg),  32'(e_cap));
      check($sformatf("i%0d.rowaddr", gi),     32'(bus.rowaddr),     32'(e_addr));
      check($sformatf("i%0d.rowaddrtoSw", gi), 32'(bus.rowaddrtoSw), 32'(e_sel));
      check($sformatf("i%0d.coreStart", gi),   32'(bus.coreStart),   32'(e_cs));
      check($sformatf("i%0d.busy", gi),        32'(bus.busy),        32'(e_busy));

      // Structural invariants, independent of the model.
      check($sformatf("i%0d.inv_sw_eq_wr", gi), 32'(bus.swEnable), 32'(bus.memRdtoReg));
      check($sformatf("i%0d.inv_onehot0", gi), 32'($onehot0(bus.rowaddrtoSw)), 32'd1);
      check($sformatf("i%0d.inv_sel_addr", gi),
            32'((bus.rowaddrtoSw == '0) || (bus.rowaddrtoSw[bus.rowaddr] === 1'b1)), 32'd1);
      check($sformatf("i%0d.inv_cs_rd", gi), 32'((bus.coreStart != 4'h0) && bus.memRD), 32'd0);

      if (e_cs != 4'h0) starts_exp++;
      if (bus.coreStart == 4'hF) begin
        starts_got++;
        $display("inst%0d rows=%0d lat=%0d: sequence %0d complete, coreStart at t=%0t",
                 gi, N, L, starts_got, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_all_idle(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (!(g_inst[0].active || g_inst[1].active || g_inst[2].active)) break;
      tick(1);
    end
    check("idle_reached",
          32'(g_inst[0].active || g_inst[1].active || g_inst[2].active), 32'd0);
  endtask

  initial begin
    // Reset held with load_req high: everything must stay quiet.
    rstn_v = '0;
    req_v  = '1;
    tick(3);
    rstn_v = '1;

    // First edge after release accepts the request and presents row 0.
    tick(1);
    check("first_rowaddr", 32'(g_inst[0].bus.rowaddr), 32'd0);
    check("first_memRD",   32'(g_inst[0].bus.memRD),   32'd1);
    check("first_busy",    32'(g_inst[0].bus.busy),    32'd1);

    // load_req held high: back-to-back sequences with a one-cycle idle gap.
    tick(120);

    // Random requests, many of them landing while busy.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) req_v[i] = ($urandom_range(0, 3) == 0);
      tick(1);
    end

    // Abort instance 2 in the middle of a WAIT cycle at row 7.
    req_v = '0;
    wait_all_idle(200);
    req_v[2] = 1'b1;
    tick(1);
    req_v[2] = 1'b0;
    tick(22);
    check("abort_pre_memRD",   32'(g_inst[2].bus.memRD),   32'd1);
    check("abort_pre_rowaddr", 32'(g_inst[2].bus.rowaddr), 32'd7);
    check("abort_pre_swEn",    32'(g_inst[2].bus.swEnable), 32'd0);
    #1 rstn_v[2] = 1'b0;
    #1;
    check("abort_memRD",   32'(g_inst[2].bus.memRD),   32'd0);
    check("abort_rowaddr", 32'(g_inst[2].bus.rowaddr), 32'd0);
    check("abort_busy",    32'(g_inst[2].bus.busy),    32'd0);
    tick(2);
    rstn_v[2] = 1'b1;
    tick(1);
    req_v[2] = 1'b1;
    tick(1);
    req_v[2] = 1'b0;
    check("restart_rowaddr", 32'(g_inst[2].bus.rowaddr), 32'd0);
    check("restart_memRD",   32'(g_inst[2].bus.memRD),   32'd1);
    wait_all_idle(200);

    // A little more random traffic, then drain.
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NI; i++) req_v[i] = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    req_v = '0;
    wait_all_idle(300);
    tick(3);

    check("starts_i0", 32'(g_inst[0].starts_got), 32'(g_inst[0].starts_exp));
    check("starts_i1", 32'(g_inst[1].starts_got), 32'(g_inst[1].starts_exp));
    check("starts_i2", 32'(g_inst[2].starts_got), 32'(g_inst[2].starts_exp));
    check("seq_seen_i0", 32'(g_inst[0].starts_exp >= 3), 32'd1);
    check("seq_seen_i1", 32'(g_inst[1].starts_exp >= 3), 32'd1);
    check("seq_seen_i2", 32'(g_inst[2].starts_exp >= 2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_controller.md
Name: load_controller

Overview:
- Front-end counterpart of the store path. On a load request it reads operand rows from data memory into the core registers, one row per transaction, routing each row through the switch.
- After the last row is loaded it pulses start to all four cores.
- It is the reader/distributor feeding the cores, where the store path is the collector/writer draining them.

Parameters:
NUM_ROWS, 16, number of memory rows to load per request (2..16)
ADDR_W, 4, row address width; must satisfy 2^ADDR_W >= NUM_ROWS
MEM_LAT, 1, data memory read latency in cycles (1..4)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
load_req  input  1  request to start a load sequence; sampled in IDLE only
memRD  output  1  read strobe to data memory
swEnable  output  1  switch enable; routes memory data bus to core registers
memRdtoReg  output  1  write-enable to core registers (capture memory row)
rowaddr  output  ADDR_W  memory row address (to memory and registers)
rowaddrtoSw  output  NUM_ROWS  one-hot row select to switch
coreStart  output  4  one-cycle start pulse, bit i to core i+1
busy  output  1  high from acceptance of load_req until return to IDLE

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, row counter=0, latency counter=0. All outputs are 0.
- All outputs are registered, driven from state and counters. There are no combinational paths from load_req to outputs.
- States: IDLE, READ, WAIT, CAPTURE, START.
- IDLE:
  - All outputs 0.
  - load_req=1 at a rising edge -> READ, row=0.
- READ (1 cycle):
  - memRD=1, rowaddr=row, busy=1.
  - -> WAIT if MEM_LAT>1, else -> CAPTURE.
- WAIT:
  - memRD=1, rowaddr=row.
  - Latency counter counts MEM_LAT-1 cycles, then -> CAPTURE.
  - Counter clears on exit.
- CAPTURE (1 cycle):
  - memRD=1, swEnable=1, memRdtoReg=1, rowaddr=row, rowaddrtoSw=one-hot(row).
  - If row==NUM_ROWS-1 -> START; else row<=row+1 -> READ.
- START (1 cycle):
  - coreStart=4'b1111, busy=1, all memory/switch outputs 0.
  - -> IDLE, row<=0.
- Per-row cost is 1+MEM_LAT cycles. Total from acceptance edge to the coreStart cycle is NUM_ROWS*(1+MEM_LAT) cycles; coreStart is asserted in the following cycle.
- rowaddrtoSw is all-zero outside CAPTURE. Exactly one bit is set in CAPTURE.
- swEnable and memRdtoReg are always asserted together, and only in CAPTURE.
- load_req while busy (READ/WAIT/CAPTURE/START) is ignored and not queued. It is not remembered after return to IDLE.
- load_req held high continuously:
  - A new sequence is accepted on the first edge in IDLE, i.e. one idle cycle after START.
  - busy is therefore low for exactly one cycle between back-to-back sequences.
- Reset mid-sequence: all outputs drop to 0 immediately (asynchronous), and the row counter returns to 0.
  - coreStart is never issued for an aborted sequence.
  - After rstn deasserts, the next load_req restarts at row 0.
- Row counter never wraps past NUM_ROWS-1. rowaddr never presents a value >= NUM_ROWS.

Test Plan:
- Reset values: hold rstn=0 for 3 cycles with load_req=1 -> all outputs 0. After release, first edge with load_req=1 -> READ, rowaddr=0, memRD=1.
- Full sequence, defaults (NUM_ROWS=16, MEM_LAT=1):
  - Expect 16 CAPTURE pulses on memRdtoReg, every 2nd cycle.
  - rowaddr 0..15 in order; rowaddrtoSw 16'h0001, 16'h0002, …, 16'h8000.
  - coreStart=4'hF for exactly one cycle, 33 cycles after the acceptance edge.
  - busy high for 33 cycles.
- Latency: MEM_LAT=3, NUM_ROWS=4 -> memRD high 3 cycles before each capture, memRdtoReg pulses spaced 4 cycles apart, coreStart in cycle 17 after acceptance.
- Request while busy: pulse load_req at rows 5 and 10 -> no restart, row sequence unchanged, exactly one coreStart. load_req held high -> busy low exactly one cycle, then new sequence starting at rowaddr=0.
- Abort: assert rstn=0 asynchronously mid-WAIT at row 7 -> memRD/rowaddr go to 0 before the next clock edge, and no coreStart is issued. A subsequent load_req restarts at row 0 and completes normally.
- Invariant checks on every cycle:
  - swEnable==memRdtoReg.
  - rowaddrtoSw is zero or one-hot, and matches rowaddr when nonzero.
  - coreStart is never asserted with memRD.
